// File: rtl/if_fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch stage.
package if_fetch_pkg;

  localparam logic [31:0] INST_NOP       = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched {addr, data} pair while IF/ID holds.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o
);

  logic        valid_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  // Clear wins over push so a redirect never leaves a stale entry behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          valid_q <= 1'b0;
    else if (clear_i) valid_q <= 1'b0;
    else if (push_i)  valid_q <= 1'b1;
    else if (pop_i)   valid_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      addr_q <= addr_i;
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, single-outstanding ibus fetch,
// output register plus one skid entry, and redirect with stale-response discard.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter logic [31:0] NOP_INST   = INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_flag_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  txn_addr_q;
  logic         out_v_q, out_v_d;
  logic [31:0]  out_addr_q, out_addr_d;
  logic [31:0]  out_data_q, out_data_d;
  logic         skid_v;
  logic [31:0]  skid_addr, skid_data;
  logic         consume, resp_live, skid_push, skid_pop, issue_ok, req, issue;

  assign consume   = out_v_q && !hold_flag_i;
  assign resp_live = (state_q == ST_WAIT) && ibus_rvalid_i;
  assign skid_pop  = consume && skid_v;
  assign skid_push = resp_live && out_v_q && !consume && !jump_flag_i;
  // Only issue when the skid will be empty next cycle, so a response always has a slot.
  assign issue_ok  = jump_flag_i || !((skid_v && !skid_pop) || skid_push);
  assign req       = (state_q == ST_REQ) && issue_ok;
  assign issue     = req && ibus_gnt_i;

  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .clear_i (jump_flag_i),
    .addr_i  (txn_addr_q),
    .data_i  (ibus_rdata_i),
    .valid_o (skid_v),
    .addr_o  (skid_addr),
    .data_o  (skid_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_REQ;
      ST_REQ:   if (issue) begin
                  state_d = ST_WAIT;
                  pc_d    = pc_q + 32'd4;
                end
      ST_WAIT:  if (ibus_rvalid_i) state_d = ST_REQ;
      ST_FLUSH: if (ibus_rvalid_i) state_d = ST_REQ;
      default:  state_d = ST_BOOT;
    endcase
    // A granted or still-pending fetch must be drained in FLUSH before refetching.
    if (jump_flag_i) begin
      pc_d = word_align(jump_addr_i);
      case (state_q)
        ST_REQ:            state_d = issue ? ST_FLUSH : ST_REQ;
        ST_WAIT, ST_FLUSH: state_d = ibus_rvalid_i ? ST_REQ : ST_FLUSH;
        default:           state_d = ST_REQ;
      endcase
    end
  end

  always_comb begin
    out_v_d    = out_v_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    if (jump_flag_i) begin
      out_v_d = 1'b0;
    end else if (consume && skid_v) begin
      out_v_d    = 1'b1;
      out_addr_d = skid_addr;
      out_data_d = skid_data;
    end else if ((consume || !out_v_q) && resp_live) begin
      out_v_d    = 1'b1;
      out_addr_d = txn_addr_q;
      out_data_d = ibus_rdata_i;
    end else if (consume) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_ADDR;
      out_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_v_q <= out_v_d;
    end
  end

  always_ff @(posedge clk) begin
    out_addr_q <= out_addr_d;
    out_data_q <= out_data_d;
    if (issue) txn_addr_q <= pc_q;
  end

  assign ibus_req_o   = req;
  assign ibus_addr_o  = word_align(pc_q);
  assign inst_valid_o = out_v_q;
  assign inst_o       = out_v_q ? out_data_q : NOP_INST;
  assign inst_addr_o  = out_v_q ? out_addr_q : 32'h0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch against a small ibus memory returning addr ^ KEY.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] KEY = 32'h5A00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        jump;
  logic [31:0] jaddr;
  logic        req, gnt, rvalid, inst_valid;
  logic [31:0] iaddr, rdata, inst_addr, inst;
  logic        gnt_en;
  logic [1:0]  lat_m1;
  logic        mem_busy;
  logic [1:0]  mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          base;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .hold_flag_i   (hold),
    .jump_flag_i   (jump),
    .jump_addr_i   (jaddr),
    .ibus_req_o    (req),
    .ibus_addr_o   (iaddr),
    .ibus_gnt_i    (gnt),
    .ibus_rvalid_i (rvalid),
    .ibus_rdata_i  (rdata),
    .inst_addr_o   (inst_addr),
    .inst_o        (inst),
    .inst_valid_o  (inst_valid)
  );

  // Memory: grants immediately when enabled, answers lat_m1+1 cycles after grant.
  assign gnt    = req & gnt_en;
  assign rvalid = mem_busy && (mem_cnt == 2'd0);
  assign rdata  = mem_addr ^ KEY;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 2'd0;
      mem_addr <= 32'h0;
    end else if (req && gnt) begin
      mem_busy <= 1'b1;
      mem_cnt  <= lat_m1;
      mem_addr <= iaddr;
    end else if (rvalid) begin
      mem_busy <= 1'b0;
    end else if (mem_busy) begin
      mem_cnt <= mem_cnt - 2'd1;
    end
  end

  // Record every instruction IF/ID actually takes.
  always @(negedge clk) begin
    if (!rst && inst_valid && !hold && !jump) begin
      log_a.push_back(inst_addr);
      log_d.push_back(inst);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] la(input int i);
    return (i < log_a.size()) ? log_a[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] ld(input int i);
    return (i < log_d.size()) ? log_d[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk_seq(input string tag, input int b, input int n, input logic [31:0] first);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      e = first + 32'(4 * i);
      chk({tag, "_addr"}, la(b + i), e);
      chk({tag, "_data"}, ld(b + i), e ^ KEY);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; hold = 1'b0; jump = 1'b0; jaddr = 32'h0; gnt_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic        t_req [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] t_bus [7] = '{32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'hC, 32'hC};
  logic        t_vld [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] t_ia  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    lat_m1 = 2'd0;
    rst = 1'b1; hold = 1'b0; jump = 1'b0; jaddr = 32'h0; gnt_en = 1'b1;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_inst", inst, INST_NOP);
    chk("rst_iaddr", inst_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_req", 32'(req), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Zero-wait streaming, then hold from the cycle 0x8 appears.
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (i == 6) hold = 1'b1;
      smp();
      chk("st_req", 32'(req), 32'(t_req[i]));
      chk("st_bus", iaddr, t_bus[i]);
      chk("st_valid", 32'(inst_valid), 32'(t_vld[i]));
      chk("st_iaddr", inst_addr, t_ia[i]);
      chk("st_inst", inst, t_vld[i] ? (t_ia[i] ^ KEY) : INST_NOP);
    end
    chk("st_log_n", 32'(log_a.size()), 32'd2);
    chk_seq("st_log", 0, 2, 32'h0);

    base = log_a.size();
    for (int i = 0; i < 5; i++) begin
      cyc();
      smp();
      chk("hold_iaddr", inst_addr, 32'h8);
      chk("hold_inst", inst, 32'h8 ^ KEY);
      chk("hold_req", 32'(req), 32'h0);
    end
    cyc(); hold = 1'b0;
    repeat (20) cyc();
    chk_seq("hold_seq", base, 6, 32'h8);

    // Redirect while WAIT with the response still outstanding.
    lat_m1 = 2'd2;
    do_reset();
    base = log_a.size();
    cyc(); smp();
    chk("jw_req1", 32'(req), 32'h1);
    cyc(); jump = 1'b1; jaddr = 32'h103; smp();
    chk("jw_req2", 32'(req), 32'h0);
    cyc(); jump = 1'b0; smp();
    chk("jw_flush_req", 32'(req), 32'h0);
    cyc(); smp();
    chk("jw_flush_valid", 32'(inst_valid), 32'h0);
    cyc(); smp();
    chk("jw_req", 32'(req), 32'h1);
    chk("jw_bus", iaddr, 32'h100);
    repeat (12) cyc();
    chk_seq("jw_seq", base, 2, 32'h100);

    // Redirect in the same cycle as rvalid.
    lat_m1 = 2'd0;
    do_reset();
    base = log_a.size();
    cyc(); smp();
    cyc(); jump = 1'b1; jaddr = 32'h200; smp();
    chk("jr_valid", 32'(inst_valid), 32'h0);
    cyc(); jump = 1'b0; smp();
    chk("jr_valid2", 32'(inst_valid), 32'h0);
    chk("jr_req", 32'(req), 32'h1);
    chk("jr_bus", iaddr, 32'h200);
    repeat (8) cyc();
    chk_seq("jr_seq", base, 2, 32'h200);

    // Redirect in the same cycle as gnt.
    do_reset();
    base = log_a.size();
    cyc(); jump = 1'b1; jaddr = 32'h300; smp();
    chk("jg_req", 32'(req), 32'h1);
    chk("jg_bus", iaddr, 32'h0);
    cyc(); jump = 1'b0; smp();
    chk("jg_flush_req", 32'(req), 32'h0);
    chk("jg_pc", iaddr, 32'h300);
    cyc(); smp();
    chk("jg_req2", 32'(req), 32'h1);
    chk("jg_valid", 32'(inst_valid), 32'h0);
    repeat (8) cyc();
    chk_seq("jg_seq", base, 2, 32'h300);

    // Redirect during BOOT to an unaligned target near the top, then wrap.
    do_reset();
    base = log_a.size();
    jump = 1'b1; jaddr = 32'hFFFF_FFFE;
    cyc(); jump = 1'b0; smp();
    chk("wr_req", 32'(req), 32'h1);
    chk("wr_bus", iaddr, 32'hFFFF_FFFC);
    cyc(); smp();
    chk("wr_pc", iaddr, 32'h0);
    cyc(); smp();
    chk("wr_iaddr", inst_addr, 32'hFFFF_FFFC);
    chk("wr_req2", 32'(req), 32'h1);
    chk("wr_bus2", iaddr, 32'h0);
    repeat (6) cyc();
    chk_seq("wr_seq", base, 2, 32'hFFFF_FFFC);

    // Asynchronous reset while WAIT with a held output.
    do_reset();
    cyc(); smp();
    cyc(); smp();
    cyc(); hold = 1'b1; lat_m1 = 2'd2; smp();
    chk("mr_pre_valid", 32'(inst_valid), 32'h1);
    cyc(); smp();
    chk("mr_pre_req", 32'(req), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("mr_inst", inst, INST_NOP);
    chk("mr_iaddr", inst_addr, 32'h0);
    chk("mr_valid", 32'(inst_valid), 32'h0);
    chk("mr_req", 32'(req), 32'h0);
    @(posedge clk); #1 rst = 1'b0; hold = 1'b0; lat_m1 = 2'd0;
    base = log_a.size();
    cyc(); smp();
    chk("mr_req1", 32'(req), 32'h1);
    chk("mr_bus1", iaddr, 32'h0);
    cyc(); smp();
    chk("mr_valid2", 32'(inst_valid), 32'h0);
    cyc(); smp();
    chk("mr_iaddr3", inst_addr, 32'h0);
    chk("mr_inst3", inst, 32'h0 ^ KEY);
    repeat (4) cyc();
    chk_seq("mr_seq", base, 2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
